// File: rtl/program_counter.sv
// Instruction-fetch program counter: registered PC, combinational PC+INCR, stall via PCWrite.
// Optional PC_ALIGN_CHECK_EN: force word alignment on load and raise a sticky AlignErr flag.
module program_counter #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter int unsigned      INCR       = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Address,
    input  logic             PCWrite,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCPlus4,
    output logic             AlignErr
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_load_addr;

`ifdef PC_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_align_err;

    assign w_misaligned = |Address[1:0];
    assign w_load_addr  = {Address[WIDTH-1:2], 2'b00};

    // Sticky until reset; only a load edge can set it, so stalls never flag stale Address bits.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_align_err <= 1'b0;
        end else if (PCWrite && w_misaligned) begin
            r_align_err <= 1'b1;
        end
    end

    assign AlignErr = r_align_err;
`else
    assign w_load_addr = Address;
    assign AlignErr    = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc <= RESET_ADDR;
        end else if (PCWrite) begin
            r_pc <= w_load_addr;
        end
    end

    assign PCResult = r_pc;
    // Modulo-2^WIDTH sum: carry-out is intentionally discarded.
    assign PCPlus4  = r_pc + WIDTH'(INCR);

endmodule

// File: tb/tb_program_counter.sv
// Directed scoreboard bench for program_counter (default WIDTH/RESET_ADDR/INCR).
// Honours PC_ALIGN_CHECK_EN so the same sequence checks either build.
module tb_program_counter;

    logic        Clk;
    logic        Reset;
    logic [31:0] Address;
    logic        PCWrite;
    logic [31:0] PCResult;
    logic [31:0] PCPlus4;
    logic        AlignErr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] plus4;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_pc;
    logic        m_err;

    program_counter #(
        .WIDTH      (32),
        .RESET_ADDR (32'h0000_0000),
        .INCR       (4)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Address  (Address),
        .PCWrite  (PCWrite),
        .PCResult (PCResult),
        .PCPlus4  (PCPlus4),
        .AlignErr (AlignErr)
    );

    initial begin
        Clk = 1'b0;
        forever #15 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.pc    = m_pc;
        e.plus4 = m_pc + 32'd4;
        e.err   = m_err;
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".pc"},    PCResult,        e.pc);
            check({e.tag, ".plus4"}, PCPlus4,         e.plus4);
            check({e.tag, ".err"},   {31'd0, AlignErr}, {31'd0, e.err});
            $display("t=%0t %s pc=%h plus4=%h err=%0b", $time, e.tag, PCResult, PCPlus4, AlignErr);
        end
    endtask

    // Drive one cycle's inputs, predict the post-edge state, then compare 1 time unit after the edge.
    task automatic cycle(input logic [31:0] addr, input logic we, input string tag);
        Address = addr;
        PCWrite = we;
        if (we) begin
`ifdef PC_ALIGN_CHECK_EN
            if (addr[1:0] != 2'b00) begin
                m_err = 1'b1;
                m_pc  = {addr[31:2], 2'b00};
            end else begin
                m_pc = addr;
            end
`else
            m_pc = addr;
`endif
        end
        push_exp(tag);
        @(posedge Clk);
        #1;
        pop_check();
    endtask

    initial begin
        m_pc    = 32'h0;
        m_err   = 1'b0;
        Reset   = 1'b1;
        PCWrite = 1'b1;
        Address = 'x;
        #2;
        Reset = 1'b0;

        // Reset held for 80 ns with Address unknown
        for (int i = 0; i < 8; i++) begin
            #10;
            push_exp("reset_hold");
            pop_check();
        end

        Reset = 1'b1;
        cycle(32'd20, 1'b1, "release");

        cycle(32'd20,  1'b1, "load20");
        cycle(32'd8,   1'b1, "load8");
        cycle(32'd52,  1'b1, "load52");
        cycle(32'd100, 1'b1, "load100");

        cycle(32'd52,  1'b1, "pre_stall");
        for (int i = 0; i < 3; i++) cycle(32'd200, 1'b0, "stall");
        cycle('x, 1'b0, "stall_x");
        cycle(32'd200, 1'b1, "unstall");

        // Asynchronous reset 7 ns after an edge, with a load pending
        cycle(32'd100, 1'b1, "pre_areset");
        #6;
        Address = 32'd300;
        PCWrite = 1'b1;
        Reset   = 1'b0;
        m_pc    = 32'h0;
        m_err   = 1'b0;
        #1;
        push_exp("areset_now");
        pop_check();
        for (int i = 0; i < 2; i++) begin
            push_exp("areset_hold");
            @(posedge Clk);
            #1;
            pop_check();
        end
        Reset = 1'b1;

        cycle(32'hFFFF_FFFC, 1'b1, "wrap");

        cycle(32'd2,  1'b1, "misalign2");
        cycle(32'd50, 1'b1, "misalign50");
        cycle(32'd8,  1'b1, "aligned_after");
        cycle(32'd7,  1'b0, "stall_misaligned");

        Reset = 1'b0;
        m_pc  = 32'h0;
        m_err = 1'b0;
        #1;
        push_exp("err_clear");
        pop_check();
        Reset = 1'b1;
        cycle(32'd12, 1'b1, "post_clear");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
